// File: rtl/ddram_pkg.sv
// Shared definitions for the DDR3 ROM download path: image base, line type, writer states.
package ddram_pkg;

   localparam logic [28:0] DDR_ROM_BASE = 29'h0600_0000;

   typedef logic [21:0] line_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_MERGE
   } state_t;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  be;
   } line_buf_t;

endpackage

// File: rtl/ddram_rom_writer.sv
// Collects 16-bit ioctl download words into 8-byte lines and writes them to the DDR3 ROM
// image over the Avalon DDRAM port, acknowledging each word on the we_req/we_ack toggle.
module ddram_rom_writer
   import ddram_pkg::*;
#(
   parameter logic [28:0] DDR_BASE   = DDR_ROM_BASE,
   parameter int          IDLE_FLUSH = 16
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [24:0] wraddr,
   input  logic [15:0] din,
   input  logic        we_req,
   output logic        we_ack,
   input  logic        flush,
   output logic        busy,
   input  logic        DDRAM_BUSY,
   output logic [28:0] DDRAM_ADDR,
   output logic [63:0] DDRAM_DIN,
   output logic [7:0]  DDRAM_BE,
   output logic        DDRAM_WE,
   output logic [7:0]  DDRAM_BURSTCNT,
   output logic        DDRAM_RD
);

   localparam int              CW       = $clog2(IDLE_FLUSH) + 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(IDLE_FLUSH - 1);

   state_t        state;
   logic [63:0]   buf_data;
   logic [7:0]    buf_be;
   line_t         buf_line;
   logic [CW-1:0] idle_cnt;
   logic          flush_pend;

   logic          pending;
   logic          buf_valid;
   line_t         req_line;
   logic [1:0]    req_lane;
   line_buf_t     merged;
   logic          take_word;
   logic          launch;
   line_buf_t     wr_buf;
   line_t         wr_line;

   function automatic line_buf_t merge_lane(input line_buf_t cur, input logic [1:0] lane,
                                            input logic [15:0] data);
      line_buf_t r;
      r = cur;
      r.data[16*lane +: 16] = data;
      r.be[2*lane +: 2]     = 2'b11;
      return r;
   endfunction

   assign pending   = (we_req != we_ack);
   assign buf_valid = |buf_be;
   assign req_line  = wraddr[24:3];
   assign req_lane  = wraddr[2:1];
   assign merged    = merge_lane('{data: buf_data, be: buf_be}, req_lane, din);

   assign busy           = buf_valid | DDRAM_WE | pending;
   assign DDRAM_BURSTCNT = 8'd1;
   assign DDRAM_RD       = 1'b0;

   // Decide this cycle whether a word is absorbed and/or a line goes out to DDR.
   always_comb begin
      take_word = 1'b0;
      launch    = 1'b0;
      wr_buf    = '{data: buf_data, be: buf_be};
      wr_line   = buf_line;
      unique case (state)
         ST_IDLE, ST_MERGE: begin
            if (pending) begin
               if (!buf_valid || req_line == buf_line) begin
                  take_word = 1'b1;
                  if (&merged.be) begin
                     launch  = 1'b1;
                     wr_buf  = merged;
                     wr_line = req_line;
                  end
               end else begin
                  launch = 1'b1;
               end
            end else if (state == ST_IDLE && buf_valid && (flush_pend || idle_cnt == CNT_LAST)) begin
               launch = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // NOTE: the line data carries no reset; buf_be marks which lanes are meaningful,
   // so clearing the enables is enough to empty the buffer.
   always_ff @(posedge clk_sys) begin
      if (take_word) begin
         buf_data <= merged.data;
         buf_line <= req_line;
      end
      if (launch) begin
         DDRAM_ADDR <= DDR_BASE + {7'd0, wr_line};
         DDRAM_DIN  <= wr_buf.data;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state      <= ST_IDLE;
         we_ack     <= 1'b0;
         DDRAM_WE   <= 1'b0;
         DDRAM_BE   <= 8'd0;
         buf_be     <= 8'd0;
         idle_cnt   <= '0;
         flush_pend <= 1'b0;
      end else begin
         if (take_word) begin
            buf_be <= merged.be;
            we_ack <= we_req;
         end
         if (launch) begin
            DDRAM_WE <= 1'b1;
            DDRAM_BE <= wr_buf.be;
         end

         unique case (state)
            ST_IDLE: begin
               if (launch)
                  state <= ST_WRITE;
               if (take_word || launch)
                  idle_cnt <= '0;
               else if (!pending && buf_valid && idle_cnt != CNT_LAST)
                  idle_cnt <= idle_cnt + 1'b1;
               if (!pending && flush_pend)
                  flush_pend <= 1'b0;
            end
            ST_WRITE: begin
               if (!DDRAM_BUSY) begin
                  DDRAM_WE <= 1'b0;
                  DDRAM_BE <= 8'd0;
                  buf_be   <= 8'd0;
                  state    <= pending ? ST_MERGE : ST_IDLE;
               end
            end
            ST_MERGE: begin
               idle_cnt <= '0;
               state    <= launch ? ST_WRITE : ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase

         // A flush arriving on the same edge that retires an earlier one must survive.
         if (flush)
            flush_pend <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ddram_rom_writer.sv
// Scoreboard bench for ddram_rom_writer: a line-buffer model predicts DDR writes, a monitor checks them.
module tb_ddram_rom_writer;

   localparam logic [28:0] BASE       = 29'h0600_0000;
   localparam int          IDLE_FLUSH = 16;

   typedef struct {
      logic [28:0] addr;
      logic [63:0] din;
      logic [7:0]  be;
   } exp_wr_t;

   logic        clk_sys;
   logic        reset;
   logic [24:0] wraddr;
   logic [15:0] din;
   logic        we_req;
   logic        we_ack;
   logic        flush;
   logic        busy;
   logic        DDRAM_BUSY;
   logic [28:0] DDRAM_ADDR;
   logic [63:0] DDRAM_DIN;
   logic [7:0]  DDRAM_BE;
   logic        DDRAM_WE;
   logic [7:0]  DDRAM_BURSTCNT;
   logic        DDRAM_RD;

   int n_checks = 0;
   int n_errors = 0;

   exp_wr_t sb_q[$];

   logic [15:0] m_data[4];
   bit          m_val[4];
   int unsigned m_line;

   bit busy_rand  = 1'b0;
   bit busy_force = 1'b0;

   ddram_rom_writer dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .wraddr         (wraddr),
      .din            (din),
      .we_req         (we_req),
      .we_ack         (we_ack),
      .flush          (flush),
      .busy           (busy),
      .DDRAM_BUSY     (DDRAM_BUSY),
      .DDRAM_ADDR     (DDRAM_ADDR),
      .DDRAM_DIN      (DDRAM_DIN),
      .DDRAM_BE       (DDRAM_BE),
      .DDRAM_WE       (DDRAM_WE),
      .DDRAM_BURSTCNT (DDRAM_BURSTCNT),
      .DDRAM_RD       (DDRAM_RD)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model: one 8-byte line of four halfwords ----------------
   function automatic bit model_any();
      return m_val[0] | m_val[1] | m_val[2] | m_val[3];
   endfunction

   task automatic model_emit();
      exp_wr_t e;
      if (!model_any()) return;
      e.addr = 29'(BASE + m_line);
      e.din  = '0;
      e.be   = '0;
      for (int k = 0; k < 4; k++) begin
         if (m_val[k]) begin
            e.din[16*k +: 16] = m_data[k];
            e.be[2*k +: 2]    = 2'b11;
         end
         m_val[k] = 1'b0;
      end
      sb_q.push_back(e);
   endtask

   task automatic model_word(input logic [24:0] a, input logic [15:0] d);
      int unsigned line;
      int          lane;
      line = int'(a[24:3]);
      lane = int'(a[2:1]);
      if (model_any() && line != m_line) model_emit();
      m_line       = line;
      m_data[lane] = d;
      m_val[lane]  = 1'b1;
      if (m_val[0] && m_val[1] && m_val[2] && m_val[3]) model_emit();
   endtask

   task automatic model_reset();
      for (int k = 0; k < 4; k++) m_val[k] = 1'b0;
      sb_q.delete();
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic req(input logic [24:0] a, input logic [15:0] d);
      @(negedge clk_sys);
      wraddr = a;
      din    = d;
      we_req = ~we_req;
      model_word(a, d);
   endtask

   task automatic wait_ack(input string name, input bit fast);
      int n;
      @(posedge clk_sys);
      #1;
      if (fast) check({name, " ack latency"}, 128'(we_ack), 128'(we_req));
      n = 0;
      while (we_ack !== we_req && n < 200) begin
         @(posedge clk_sys);
         #1;
         n++;
      end
      if (!fast) check({name, " ack"}, 128'(we_ack), 128'(we_req));
   endtask

   task automatic pulse_flush();
      @(negedge clk_sys);
      flush = 1'b1;
      model_emit();
      @(negedge clk_sys);
      flush = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((busy !== 1'b0 || DDRAM_WE !== 1'b0) && n < 500) begin
         @(posedge clk_sys);
         #1;
         n++;
      end
      check({name, " busy"}, 128'(busy), 128'(0));
   endtask

   // Waitrequest driver: updated just after each rising edge, stable through the next one.
   initial begin
      DDRAM_BUSY = 1'b0;
      forever begin
         @(posedge clk_sys);
         #2;
         DDRAM_BUSY = busy_rand ? ($urandom_range(0, 3) == 0) : busy_force;
      end
   end

   // Monitor: a beat with WE high and BUSY low at the falling edge is accepted on the next rise.
   initial begin
      exp_wr_t     e;
      logic [63:0] mask;
      forever begin
         @(negedge clk_sys);
         if (reset === 1'b0 && DDRAM_WE === 1'b1 && DDRAM_BUSY === 1'b0) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected ddr write: got addr=%0h be=%0h din=%0h expected none",
                        DDRAM_ADDR, DDRAM_BE, DDRAM_DIN);
            end else begin
               e = sb_q.pop_front();
               for (int b = 0; b < 8; b++) mask[8*b +: 8] = {8{e.be[b]}};
               check("ddr write {addr,be,din}",
                     128'({DDRAM_ADDR, DDRAM_BE, DDRAM_DIN & mask}),
                     128'({e.addr, e.be, e.din & mask}));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- directed and random sequences ----------------
   initial begin
      int n;
      reset  = 1'b1;
      wraddr = '0;
      din    = '0;
      we_req = 1'b0;
      flush  = 1'b0;
      model_reset();
      repeat (3) @(posedge clk_sys);
      #1;
      check("reset we_ack", 128'(we_ack), 128'(0));
      check("reset DDRAM_WE", 128'(DDRAM_WE), 128'(0));
      check("reset DDRAM_BE", 128'(DDRAM_BE), 128'(0));
      check("reset busy", 128'(busy), 128'(0));
      check("burstcnt/rd", 128'({DDRAM_BURSTCNT, DDRAM_RD}), 128'({8'd1, 1'b0}));
      @(negedge clk_sys);
      reset = 1'b0;

      // Full line in four back-to-back words.
      req(25'h0, 16'h1111); wait_ack("w0", 1'b1);
      req(25'h2, 16'h2222); wait_ack("w2", 1'b1);
      req(25'h4, 16'h3333); wait_ack("w4", 1'b1);
      req(25'h6, 16'h4444); wait_ack("w6", 1'b1);
      wait_idle("full line");

      // Different line while DDR stalls: second word held until the first write is taken.
      req(25'h8, 16'h0808); wait_ack("w8", 1'b1);
      @(negedge clk_sys);
      busy_force = 1'b1;
      repeat (2) @(posedge clk_sys);
      req(25'h20, 16'h2020);
      repeat (5) @(posedge clk_sys);
      #1;
      check("deferred req held", 128'(we_ack ^ we_req), 128'(1));
      check("write held under busy", 128'(DDRAM_WE), 128'(1));
      @(negedge clk_sys);
      busy_force = 1'b0;
      wait_ack("w20", 1'b0);
      pulse_flush();
      wait_idle("deferred");

      // Lone word drained by the idle timer.
      req(25'h12, 16'h1212); wait_ack("w12", 1'b1);
      model_emit();
      n = 0;
      while (DDRAM_WE !== 1'b1 && n < 64) begin
         @(posedge clk_sys);
         #1;
         n++;
      end
      check("idle flush delay", 128'(n), 128'(IDLE_FLUSH));
      check("busy during idle write", 128'(busy), 128'(1));
      @(posedge clk_sys);
      #1;
      check("busy after accept", 128'(busy), 128'(0));

      // Request and flush on the same edge.
      @(negedge clk_sys);
      flush  = 1'b1;
      wraddr = 25'h40;
      din    = 16'h4040;
      we_req = ~we_req;
      model_word(25'h40, 16'h4040);
      model_emit();
      wait_ack("w40+flush", 1'b1);
      @(negedge clk_sys);
      flush = 1'b0;
      wait_idle("req with flush");
      repeat (IDLE_FLUSH + 4) @(posedge clk_sys);

      // Reset while a write is stalled: beat and buffer are abandoned.
      @(negedge clk_sys);
      busy_force = 1'b1;
      repeat (2) @(posedge clk_sys);
      req(25'h100, 16'h5A5A); wait_ack("w100", 1'b1);
      pulse_flush();
      n = 0;
      while (DDRAM_WE !== 1'b1 && n < 50) begin
         @(posedge clk_sys);
         #1;
         n++;
      end
      check("stalled write present", 128'(DDRAM_WE), 128'(1));
      @(negedge clk_sys);
      reset  = 1'b1;
      we_req = 1'b0;
      @(posedge clk_sys);
      #1;
      check("reset mid-write {we,ack,busy}", 128'({DDRAM_WE, we_ack, busy}), 128'(0));
      model_reset();
      @(negedge clk_sys);
      reset      = 1'b0;
      busy_force = 1'b0;
      repeat (40) @(posedge clk_sys);

      // Same lane written twice before the line goes out.
      req(25'h0, 16'hAAAA); wait_ack("rewrite a", 1'b1);
      req(25'h0, 16'hBBBB); wait_ack("rewrite b", 1'b1);
      pulse_flush();
      wait_idle("rewrite");

      // Random words over a few lines with a randomly stalling DDR port.
      busy_rand = 1'b1;
      for (int i = 0; i < 120; i++) begin
         logic [21:0] line;
         logic [24:0] a;
         repeat ($urandom_range(0, 3)) @(posedge clk_sys);
         if ($urandom_range(0, 9) == 0) begin
            pulse_flush();
         end else begin
            line = ($urandom_range(0, 7) == 0) ? 22'h3F_FFFF : 22'($urandom_range(0, 3));
            a    = {line, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))};
            req(a, 16'($urandom));
            wait_ack("random", 1'b0);
         end
      end
      busy_rand = 1'b0;
      pulse_flush();
      wait_idle("random drain");
      repeat (4) @(posedge clk_sys);
      check("scoreboard empty", 128'(sb_q.size()), 128'(0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
